// File: rtl/wb_queue_if.sv
// Writeback queue bus: the two producer handshakes (ALU and load), the
// register-file write port, the bypass lookup and the occupancy report.
// The queue takes the slave side; whoever feeds it and consumes the
// register-file writes takes the master side.
interface wb_queue_if;
    logic       alu_valid;
    logic [2:0] alu_rd;
    logic [7:0] alu_data;
    logic       alu_ready;

    logic       mem_valid;
    logic [2:0] mem_rd;
    logic [7:0] mem_data;
    logic       mem_ready;

    logic       rf_write;
    logic [2:0] rf_regw;
    logic [7:0] rf_dataw;

    logic [2:0] fwd_rd;
    logic       fwd_hit;
    logic [7:0] fwd_data;

    logic [3:0] count;

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        input  rf_write, rf_regw, rf_dataw,
        output fwd_rd,
        input  fwd_hit, fwd_data,
        input  count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        output rf_write, rf_regw, rf_dataw,
        input  fwd_rd,
        output fwd_hit, fwd_data,
        output count
    );
endinterface

// File: rtl/wb_queue.sv
// Writeback queue: merges ALU and load results into a circular FIFO that
// drains one entry per cycle into the register file, and offers a bypass
// lookup returning the youngest pending value for a register.
// Optional feature macro: WB_R0_DISCARD_EN -- writes to register 0 complete
// their handshake but are dropped, and register 0 never forwards.
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    wb_queue_if.slave  bus
);
    localparam int         PW      = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    // Entry storage; contents are only meaningful inside [head, head+count)
    logic [2:0]    slot_rd   [DEPTH];
    logic [7:0]    slot_data [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW-1:0] alu_slot;
    logic [3:0]    count_q, count_d;
    logic [3:0]    free;

    logic          mem_rdy, alu_rdy;
    logic          mem_keep, alu_keep;
    logic          mem_enq, alu_enq;
    logic          pop;
    logic          fwd_r0_mask;

    logic          rf_write_c;
    logic [2:0]    rf_regw_c;
    logic [7:0]    rf_dataw_c;
    logic          fwd_hit_c;
    logic [7:0]    fwd_data_c;

    // Admission: readiness from registered occupancy only, load path first
    always_comb begin
        free    = DEPTH_C - count_q;
        mem_rdy = (free >= 4'd1);
        alu_rdy = (free >= 4'd2) || ((free == 4'd1) && !bus.mem_valid);
`ifdef WB_R0_DISCARD_EN
        mem_keep    = (bus.mem_rd != 3'd0);
        alu_keep    = (bus.alu_rd != 3'd0);
        fwd_r0_mask = (bus.fwd_rd == 3'd0);
`else
        mem_keep    = 1'b1;
        alu_keep    = 1'b1;
        fwd_r0_mask = 1'b0;
`endif
        mem_enq = bus.mem_valid && mem_rdy && mem_keep;
        alu_enq = bus.alu_valid && alu_rdy && alu_keep;
        pop     = (count_q != 4'd0);
    end

    // Next pointers and occupancy; the ALU entry lands behind the load entry
    always_comb begin
        alu_slot = mem_enq ? (tail_q + PW'(1)) : tail_q;
        tail_d   = tail_q + PW'(mem_enq) + PW'(alu_enq);
        head_d   = head_q + PW'(pop);
        count_d  = count_q + 4'(mem_enq) + 4'(alu_enq) - 4'(pop);
    end

    // Control state clears the instant reset rises, discarding pending entries
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload writes; occupancy gates visibility so no reset is needed
    always_ff @(posedge clock) begin
        if (mem_enq) begin
            slot_rd[tail_q]   <= bus.mem_rd;
            slot_data[tail_q] <= bus.mem_data;
        end
        if (alu_enq) begin
            slot_rd[alu_slot]   <= bus.alu_rd;
            slot_data[alu_slot] <= bus.alu_data;
        end
    end

    // Head presentation and youngest-match bypass search (later slots win)
    always_comb begin
        rf_write_c = pop;
        rf_regw_c  = pop ? slot_rd[head_q]   : 3'd0;
        rf_dataw_c = pop ? slot_data[head_q] : 8'd0;
        fwd_hit_c  = 1'b0;
        fwd_data_c = 8'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((4'(i) < count_q) && (slot_rd[head_q + PW'(i)] == bus.fwd_rd)) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = slot_data[head_q + PW'(i)];
            end
        end
        if (fwd_r0_mask) begin
            fwd_hit_c  = 1'b0;
            fwd_data_c = 8'd0;
        end
    end

    assign bus.mem_ready = mem_rdy;
    assign bus.alu_ready = alu_rdy;
    assign bus.rf_write  = rf_write_c;
    assign bus.rf_regw   = rf_regw_c;
    assign bus.rf_dataw  = rf_dataw_c;
    assign bus.fwd_hit   = fwd_hit_c;
    assign bus.fwd_data  = fwd_data_c;
    assign bus.count     = count_q;
endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL provide parameter: DEPTH, 4, writeback queue entries (power of two, 2..8).
REQ-002 SHALL provide ports, one per line:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- alu_valid  in  1  ALU result valid.
- alu_rd  in  3  ALU destination register.
- alu_data  in  8  ALU result.
- alu_ready  out  1  queue accepts ALU result.
- mem_valid  in  1  load result valid.
- mem_rd  in  3  load destination register.
- mem_data  in  8  load data.
- mem_ready  out  1  queue accepts load result.
- rf_write  out  1  register-file write enable.
- rf_regw  out  3  register-file write address.
- rf_dataw  out  8  register-file write data.
- fwd_rd  in  3  bypass lookup register.
- fwd_hit  out  1  pending write to fwd_rd exists.
- fwd_data  out  8  youngest pending value for fwd_rd.
- count  out  4  queue occupancy, 0..DEPTH.

Function
REQ-003 SHALL store entries {rd, data} in a circular FIFO with wrap-around head/tail pointers and a separate occupancy counter.
REQ-004 SHALL treat a source as accepted on a rising edge when valid and ready are both high.
REQ-005 SHALL compute free = DEPTH - count from registered state only; no credit for a same-cycle drain.
REQ-006 SHALL drive mem_ready = (free >= 1).
REQ-007 SHALL drive alu_ready = (free >= 2) or (free == 1 and mem_valid == 0); the load path has priority.
REQ-008 SHALL, when both sources are accepted on the same edge, enqueue the mem entry first and the alu entry second.
REQ-009 SHALL drive rf_write = (count != 0) combinationally, with rf_regw/rf_dataw taken from the head entry; 0 when empty.
REQ-010 SHALL pop the head on every edge where count != 0; the register file always accepts.
REQ-011 SHALL update count by (accepted entries - popped entry) per edge, including simultaneous enqueue and pop.
REQ-012 SHALL give a latency of one edge: an entry accepted at edge k into an empty queue appears on rf_* during the cycle after edge k and is written at edge k+1.
REQ-013 SHALL drive fwd_hit/fwd_data combinationally from the youngest valid entry whose rd equals fwd_rd, including the head; on a miss, fwd_hit = 0 and fwd_data = 0x00.
REQ-014 SHALL never overflow or underflow; REQ-006/007 guarantee at most free entries enqueued.

Reset
REQ-015 SHALL, while reset is high, clear pointers and count immediately without a clock edge, forcing rf_write = 0, fwd_hit = 0, count = 0, mem_ready = alu_ready = 1.
REQ-016 SHALL discard pending entries on reset mid-operation; discarded entries are never written.

Configuration
REQ-017 SHALL support macro WB_R0_DISCARD_EN. When defined, an accepted entry with rd == 0 completes its handshake but is not enqueued, and fwd_hit is 0 for fwd_rd == 0. When undefined, register 0 behaves as any other register.

Verification
REQ-018 Empty queue, alu_valid=1, rd=3, data=0x5A for one edge -> next cycle rf_write=1, rf_regw=3, rf_dataw=0x5A, count=1; following cycle count=0, rf_write=0.
REQ-019 Same edge: mem rd=2, data=0x11 and alu rd=2, data=0x22 -> rf writes 0x11 then 0x22 on consecutive cycles; fwd_rd=2 gives hit=1, data=0x22 while both are pending.
REQ-020 DEPTH=4, both sources valid continuously from empty -> count goes 0,2,3,3; from the third cycle on, alu_ready=0 while mem_valid=1; alu data is held and accepted when mem_valid drops.
REQ-021 count=3, reset asserted mid-cycle -> rf_write=0 and count=0 before the next edge; none of the 3 entries reach the register file.
REQ-022 WB_R0_DISCARD_EN defined, alu rd=0, data=0xFF accepted -> alu_ready=1, count stays 0, rf_write stays 0; undefined -> rf_write=1, rf_regw=0, rf_dataw=0xFF.
REQ-023 Empty queue, fwd_rd=5 -> fwd_hit=0, fwd_data=0x00.
